// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the MEM stage and a word-indexed RAM backend.
// One transaction in flight: accept -> (optional read wait) -> response handshake.
//
// state   | meaning
// IDLE    | ready for a request; strobes issued combinationally on accept
// RD_WAIT | load issued, counting down backend read latency
// RESP    | response presented, held until rsp_ready
module lsu_mem_ctrl #(
  parameter int              DATA_W    = 64,
  parameter int              ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000),
  parameter int              RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_idx,
  output logic [DATA_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              accept;
  logic [OFF_W-1:0]  req_off;
  logic              align_err;
  logic              size_err;
  logic              req_err;
  logic [DATA_W-1:0] req_mask;
  logic [DATA_W-1:0] ld_sh;
  logic [DATA_W-1:0] ld_mask;
  logic [DATA_W-1:0] ld_top;
  logic              ld_neg;
  logic [DATA_W-1:0] ld_ext;

  // Low (8<<sz) bits set: the byte span of an access of the given size.
  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] sz);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < DATA_W; i++) m[i] = (i < (8 << sz));
    return m;
  endfunction

  // Request decode: lane offset, alignment and size legality.
  always_comb begin
    req_off   = req_addr[OFF_W-1:0];
    unique case (req_size)
      2'd0:    align_err = 1'b0;
      2'd1:    align_err = req_addr[0];
      2'd2:    align_err = |req_addr[1:0];
      default: align_err = |req_addr[2:0];
    endcase
    size_err  = (req_size == 2'd3) && (DATA_W == 32);
    req_err   = align_err || size_err;
    req_mask  = size_mask(req_size);
    // Reset gates acceptance so no strobe leaks out while rst is low.
    accept    = req_valid && req_ready && rst;
  end

  // Load extraction: shift lane down, truncate to size, extend by top bit.
  always_comb begin
    ld_sh   = mem_rdata >> {off_q, 3'b000};
    ld_mask = size_mask(size_q);
    ld_top  = ld_mask ^ (ld_mask >> 1);
    ld_neg  = sgn_q && (|(ld_sh & ld_top));
    ld_ext  = ld_neg ? (ld_sh | ~ld_mask) : (ld_sh & ld_mask);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = (req_err || req_we) ? RESP : RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_q == 2'd0) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshakes from state, backend strobes only in an aligned accept cycle.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_idx   = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (accept && !req_err) begin
      mem_idx = (req_addr - BASE_ADDR) >> OFF_W;
      if (req_we) begin
        mem_wen   = 1'b1;
        mem_wmask = req_mask << {req_off, 3'b000};
        mem_wdata = (req_wdata & req_mask) << {req_off, 3'b000};
      end else begin
        mem_ren = 1'b1;
      end
    end
  end

  // Transaction context, latency counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        off_q  <= req_off;
        size_q <= req_size;
        sgn_q  <= req_signed;
        cnt_q  <= CNT_INIT;
        if (req_err || req_we) begin
          rdata_q <= '0;
          err_q   <= req_err;
        end
      end
      if (state_q == RD_WAIT) begin
        if (cnt_q == 2'd0) begin
          rdata_q <= ld_ext;
          err_q   <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 2'd1;
        end
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl (DATA_W=64, RD_LAT=3) with a small latency-modelled RAM.
module tb_lsu_mem_ctrl;

  localparam int DW  = 64;
  localparam int AW  = 64;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_ren;
  logic          mem_wen;
  logic [AW-1:0] mem_idx;
  logic [DW-1:0] mem_wmask;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  lsu_mem_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(64'h8000_0000), .RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_idx(mem_idx),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Backend: 16-word RAM, read data valid LAT cycles after mem_ren, garbage otherwise.
  logic [63:0] ram [0:15];
  logic        pv   [0:LAT-1];
  logic [3:0]  pidx [0:LAT-1];

  always @(posedge clk) begin
    pv[0]   <= mem_ren;
    pidx[0] <= mem_idx[3:0];
    for (int i = 1; i < LAT; i++) begin
      pv[i]   <= pv[i-1];
      pidx[i] <= pidx[i-1];
    end
    if (mem_wen)
      ram[mem_idx[3:0]] <= (ram[mem_idx[3:0]] & ~mem_wmask) | (mem_wdata & mem_wmask);
  end

  assign mem_rdata = (pv[LAT-1] === 1'b1) ? ram[pidx[LAT-1]] : 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  // Monitor: every response handshake pops one expectation.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp: got response rdata=%h with none pending", rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk1("rsp_err", rsp_err, e.err);
        end
      end
    end
  end

  task automatic push_exp(input logic [63:0] rd, input logic er);
    rsp_t e;
    e.rdata = rd;
    e.err   = er;
    exp_q.push_back(e);
  endtask

  // One request: checks accept-cycle strobes, response latency, optional backpressure.
  task automatic do_req(input string nm, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_er,
                        input logic [63:0] exp_idx, input logic [63:0] exp_mask,
                        input logic [63:0] exp_wd, input int hold);
    int lat;
    int exp_lat;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    rsp_ready  = (hold == 0);
    #1;
    chk1({nm, ".req_ready"}, req_ready, 1'b1);
    if (exp_er) begin
      chk1({nm, ".mem_ren"}, mem_ren, 1'b0);
      chk1({nm, ".mem_wen"}, mem_wen, 1'b0);
    end else if (we) begin
      chk1({nm, ".mem_wen"}, mem_wen, 1'b1);
      chk1({nm, ".mem_ren"}, mem_ren, 1'b0);
      chk({nm, ".mem_idx"}, mem_idx, exp_idx);
      chk({nm, ".mem_wmask"}, mem_wmask, exp_mask);
      chk({nm, ".mem_wdata"}, mem_wdata, exp_wd);
    end else begin
      chk1({nm, ".mem_ren"}, mem_ren, 1'b1);
      chk1({nm, ".mem_wen"}, mem_wen, 1'b0);
      chk({nm, ".mem_idx"}, mem_idx, exp_idx);
    end
    push_exp(exp_rd, exp_er);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    exp_lat = (exp_er || we) ? 1 : LAT + 1;
    lat = 1;
    while (lat <= 20) begin
      #1;
      if (rsp_valid === 1'b1) break;
      @(negedge clk);
      lat++;
    end
    chk({nm, ".latency"}, 64'(lat), 64'(exp_lat));
    for (int k = 0; k < hold; k++) begin
      chk1({nm, ".hold_valid"}, rsp_valid, 1'b1);
      chk({nm, ".hold_rdata"}, rsp_rdata, exp_rd);
      chk1({nm, ".hold_req_ready"}, req_ready, 1'b0);
      @(negedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk1({nm, ".req_ready_after"}, req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw;
    ram[0]  = 64'h0;
    ram[1]  = 64'h8000_1234_5678_9ABC;
    ram[2]  = 64'h0123_4567_89AB_CDEF;
    ram[3]  = 64'h1111_1111_1111_1111;
    for (int i = 4; i < 16; i++) ram[i] = 64'h0;

    // Reset with a store already requested.
    rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 64'h8000_0005; req_wdata = 64'hFFEE_DDCC_BBAA_99AB; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk1("rst.req_ready", req_ready, 1'b1);
    chk1("rst.rsp_valid", rsp_valid, 1'b0);
    chk1("rst.mem_ren", mem_ren, 1'b0);
    chk1("rst.mem_wen", mem_wen, 1'b0);
    chk("rst.mem_wmask", mem_wmask, 64'h0);
    chk("rst.rsp_rdata", rsp_rdata, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("sb.mem_wen", mem_wen, 1'b1);
    chk("sb.mem_idx", mem_idx, 64'h0);
    chk("sb.mem_wmask", mem_wmask, 64'h0000_FF00_0000_0000);
    chk("sb.mem_wdata", mem_wdata, 64'h0000_AB00_0000_0000);
    push_exp(64'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk1("sb.rsp_valid", rsp_valid, 1'b1);
    @(negedge clk);
    #1;
    chk1("sb.req_ready_after", req_ready, 1'b1);

    //     name      we    sz    sg    addr                   wdata                  exp_rdata              err   idx                    mask                   wdata_lane             hold
    do_req("lbu",    1'b0, 2'd0, 1'b0, 64'h8000_0005,         64'h0,                 64'h0000_0000_0000_00AB, 1'b0, 64'h0,               64'h0,                 64'h0,                 0);
    do_req("lb",     1'b0, 2'd0, 1'b1, 64'h8000_0005,         64'h0,                 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, 64'h0,               64'h0,                 64'h0,                 0);
    do_req("lh",     1'b0, 2'd1, 1'b1, 64'h8000_000E,         64'h0,                 64'hFFFF_FFFF_FFFF_8000, 1'b0, 64'h1,               64'h0,                 64'h0,                 0);
    do_req("lhu",    1'b0, 2'd1, 1'b0, 64'h8000_000E,         64'h0,                 64'h0000_0000_0000_8000, 1'b0, 64'h1,               64'h0,                 64'h0,                 0);
    do_req("lw_mis", 1'b0, 2'd2, 1'b1, 64'h8000_0006,         64'h0,                 64'h0,                   1'b1, 64'h0,               64'h0,                 64'h0,                 0);
    do_req("sd_mis", 1'b1, 2'd3, 1'b0, 64'h8000_0004,         64'h1234,              64'h0,                   1'b1, 64'h0,               64'h0,                 64'h0,                 0);
    do_req("ld_bp",  1'b0, 2'd3, 1'b0, 64'h8000_0010,         64'h0,                 64'h0123_4567_89AB_CDEF, 1'b0, 64'h2,               64'h0,                 64'h0,                 5);
    do_req("lw",     1'b0, 2'd2, 1'b1, 64'h8000_0010,         64'h0,                 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 64'h2,               64'h0,                 64'h0,                 0);
    do_req("lwu_hi", 1'b0, 2'd2, 1'b0, 64'h8000_0014,         64'h0,                 64'h0000_0000_0123_4567, 1'b0, 64'h2,               64'h0,                 64'h0,                 0);
    do_req("sh",     1'b1, 2'd1, 1'b0, 64'h8000_001A,         64'h1234_5678_9ABC_BEEF, 64'h0,                 1'b0, 64'h3,               64'h0000_0000_FFFF_0000, 64'h0000_0000_BEEF_0000, 0);
    do_req("ld_sh",  1'b0, 2'd3, 1'b0, 64'h8000_0018,         64'h0,                 64'h1111_1111_BEEF_1111, 1'b0, 64'h3,               64'h0,                 64'h0,                 0);
    do_req("sd_wrap",1'b1, 2'd3, 1'b0, 64'h0000_0000_7FFF_FFF8, 64'hCAFE_F00D_0BAD_BEEF, 64'h0,               1'b0, 64'h1FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hCAFE_F00D_0BAD_BEEF, 0);
    do_req("ld_wrap",1'b0, 2'd3, 1'b1, 64'h0000_0000_7FFF_FFF8, 64'h0,               64'hCAFE_F00D_0BAD_BEEF, 1'b0, 64'h1FFF_FFFF_FFFF_FFFF, 64'h0,               64'h0,                 0);
    do_req("sb_lo",  1'b1, 2'd0, 1'b0, 64'h8000_0000,         64'h0000_0000_0000_0055, 64'h0,                 1'b0, 64'h0,               64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0055, 0);
    do_req("sb_hi",  1'b1, 2'd0, 1'b0, 64'h8000_0007,         64'h0000_0000_0000_0077, 64'h0,                 1'b0, 64'h0,               64'hFF00_0000_0000_0000, 64'h7700_0000_0000_0000, 0);
    do_req("ld_w0",  1'b0, 2'd3, 1'b0, 64'h8000_0000,         64'h0,                 64'h7700_AB00_0000_0055, 1'b0, 64'h0,               64'h0,                 64'h0,                 0);

    // Reset in the middle of a read wait; the late backend data must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_signed = 1'b0;
    req_addr = 64'h8000_0008; rsp_ready = 1'b1;
    #1;
    chk1("rdrst.mem_ren", mem_ren, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk1("rdrst.rsp_valid", rsp_valid, 1'b0);
    chk1("rdrst.req_ready", req_ready, 1'b1);
    chk1("rdrst.mem_ren", mem_ren, 1'b0);
    chk("rdrst.rsp_rdata", rsp_rdata, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 1'b0) saw = 1'b1;
    end
    chk1("rdrst.stale_rsp", saw, 1'b0);
    chk("pending_at_end", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
